// File: rtl/md_sched.sv
// Multiply/divide sequencer for the EX stage: owns HI/LO, runs MULT in a fixed
// latency pipeline and DIV in a radix-2 restoring divider, and requests stalls.
module md_sched #(
   parameter int MUL_LAT  = 4,
   parameter int DIV_ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  func,
   input  logic        is_sign,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_hilo,
   input  logic        flush,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall_req
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   localparam logic [2:0] FUNC_NONE = 3'b000;
   localparam logic [2:0] FUNC_MULT = 3'b001;
   localparam logic [2:0] FUNC_DIV  = 3'b010;
   localparam logic [2:0] FUNC_MTHI = 3'b011;
   localparam logic [2:0] FUNC_MTLO = 3'b100;

   state_t        state_q, state_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic [63:0]   prod_q [MUL_LAT];
   logic [63:0]   prod_d [MUL_LAT];
   logic [31:0]   quo_q, quo_d;
   logic [32:0]   rem_q, rem_d;
   logic [31:0]   dvsr_q, dvsr_d;
   logic          negQ_q, negQ_d;
   logic          negR_q, negR_d;

   logic          accept;
   logic signed [63:0] prodS;
   logic [63:0]   prodU;
   logic [63:0]   mulProd;
   logic [31:0]   absA, absB;
   logic [33:0]   remShift;
   logic [33:0]   diff;

   assign prodS   = $signed(a) * $signed(b);
   assign prodU   = {32'b0, a} * {32'b0, b};
   assign mulProd = is_sign ? prodS : prodU;

   // Signed 0x80000000 negates to itself, which is already its correct magnitude.
   assign absA = (is_sign & a[31]) ? -a : a;
   assign absB = (is_sign & b[31]) ? -b : b;

   assign remShift = {rem_q, quo_q[31]};
   assign diff     = remShift - {2'b0, dvsr_q};

   assign accept    = start & ~flush & (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign stall_req = busy & ((start & (func != FUNC_NONE)) | rd_hilo);

   assign hi = hi_q;
   assign lo = lo_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvsr_d  = dvsr_q;
      negQ_d  = negQ_q;
      negR_d  = negR_q;
      prod_d[0] = prod_q[0];
      for (int i = 1; i < MUL_LAT; i++) begin
         prod_d[i] = prod_q[i-1];
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               case (func)
                  FUNC_MULT: begin
                     state_d   = MUL;
                     cnt_d     = 6'd1;
                     prod_d[0] = mulProd;
                  end
                  FUNC_DIV: begin
                     if (b == 32'd0) begin
                        // Divide by zero skips the iterations; FIX commits these raw.
                        state_d = FIX;
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = {1'b0, a};
                        negQ_d  = 1'b0;
                        negR_d  = 1'b0;
                     end else begin
                        state_d = DIV;
                        cnt_d   = 6'd0;
                        quo_d   = absA;
                        rem_d   = 33'd0;
                        dvsr_d  = absB;
                        negQ_d  = is_sign & (a[31] ^ b[31]);
                        negR_d  = is_sign & a[31];
                     end
                  end
                  FUNC_MTHI: hi_d = a;
                  FUNC_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end

         MUL: begin
            if (cnt_q == 6'(MUL_LAT)) begin
               {hi_d, lo_d} = prod_q[MUL_LAT-1];
               state_d      = IDLE;
               cnt_d        = 6'd0;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end

         DIV: begin
            // The dividend shifts out of quo_q while quotient bits shift in.
            if (!diff[33]) begin
               rem_d = diff[32:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = remShift[32:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            if (cnt_q == 6'(DIV_ITER - 1)) begin
               state_d = FIX;
               cnt_d   = 6'd0;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end

         FIX: begin
            lo_d    = negQ_q ? -quo_q : quo_q;
            hi_d    = negR_q ? -rem_q[31:0] : rem_q[31:0];
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         quo_q   <= 32'd0;
         rem_q   <= 33'd0;
         dvsr_q  <= 32'd0;
         negQ_q  <= 1'b0;
         negR_q  <= 1'b0;
         for (int i = 0; i < MUL_LAT; i++) begin
            prod_q[i] <= 64'd0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvsr_q  <= dvsr_d;
         negQ_q  <= negQ_d;
         negR_q  <= negR_d;
         for (int i = 0; i < MUL_LAT; i++) begin
            prod_q[i] <= prod_d[i];
         end
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// Testbench for md_sched: a behavioural model predicts HI/LO and busy length
// per issued op into a scoreboard queue, popped when the unit goes idle.
module tb_md_sched;

   localparam int MUL_LAT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  func = 3'b000;
   logic        is_sign = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        rd_hilo = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] hi, lo;
   logic        busy, stall_req;

   md_sched #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
      .clk(clk), .rst(rst), .start(start), .func(func), .is_sign(is_sign),
      .a(a), .b(b), .rd_hilo(rd_hilo), .flush(flush),
      .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          testsRun = 0;
   int          testsFailed = 0;
   logic [31:0] modelHi = 32'd0;
   logic [31:0] modelLo = 32'd0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      testsRun++;
      if (obs !== expv) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Predicts the architectural outcome of one issued op and queues it.
   task automatic predictOp(input logic [2:0] f, input logic s, input logic [31:0] aa,
                            input logic [31:0] bb, input string tag);
      exp_t        e;
      longint      sa, sbv, q, r;
      logic [63:0] p;
      e.tag = tag;
      e.hi  = modelHi;
      e.lo  = modelLo;
      e.lat = 0;
      sa  = longint'($signed(aa));
      sbv = longint'($signed(bb));
      case (f)
         3'b001: begin
            p     = s ? 64'(sa * sbv) : ({32'b0, aa} * {32'b0, bb});
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.lat = MUL_LAT;
         end
         3'b010: begin
            if (bb == 32'd0) begin
               e.hi  = aa;
               e.lo  = 32'hFFFF_FFFF;
               e.lat = 1;
            end else if (s) begin
               q     = sa / sbv;
               r     = sa % sbv;
               e.lo  = q[31:0];
               e.hi  = r[31:0];
               e.lat = 33;
            end else begin
               e.lo  = aa / bb;
               e.hi  = aa % bb;
               e.lat = 33;
            end
         end
         3'b011: e.hi = aa;
         3'b100: e.lo = aa;
         default: ;
      endcase
      modelHi = e.hi;
      modelLo = e.lo;
      sb.push_back(e);
   endtask

   // holdMode: 0 quiet, 1 rd_hilo held while busy, 2 an MTLO start held while busy.
   task automatic applyStimulus(input logic [2:0] f, input logic s, input logic [31:0] aa,
                                input logic [31:0] bb, input int holdMode, input string tag);
      exp_t e;
      int   cycles;
      int   stalls;
      @(negedge clk);
      start   = 1'b1;
      func    = f;
      is_sign = s;
      a       = aa;
      b       = bb;
      predictOp(f, s, aa, bb, tag);
      @(negedge clk);
      start = 1'b0;
      func  = 3'b000;
      if (holdMode == 1) rd_hilo = 1'b1;
      if (holdMode == 2) begin
         start = 1'b1;
         func  = 3'b100;
         a     = 32'hDEAD_BEEF;
      end
      #1;
      cycles = 0;
      stalls = 0;
      while (busy === 1'b1 && cycles < 100) begin
         cycles++;
         if (stall_req === 1'b1) stalls++;
         @(negedge clk);
         #1;
      end
      start   = 1'b0;
      func    = 3'b000;
      rd_hilo = 1'b0;
      e = sb.pop_front();
      checkOutput({e.tag, " busy cycles"}, 64'(cycles), 64'(e.lat));
      checkOutput({e.tag, " stall cycles"}, 64'(stalls), (holdMode != 0) ? 64'(e.lat) : 64'd0);
      checkOutput({e.tag, " hi"}, {32'd0, hi}, {32'd0, e.hi});
      checkOutput({e.tag, " lo"}, {32'd0, lo}, {32'd0, e.lo});
   endtask

   initial begin
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst     = 1'b1;
      rd_hilo = 1'b1;
      #1;
      checkOutput("reset hi", {32'd0, hi}, 64'd0);
      checkOutput("reset lo", {32'd0, lo}, 64'd0);
      checkOutput("reset busy", {63'd0, busy}, 64'd0);
      checkOutput("reset stall_req idle", {63'd0, stall_req}, 64'd0);
      rd_hilo = 1'b0;

      applyStimulus(3'b001, 1'b0, 32'hFFFF_FFFF, 32'd2, 0, "multu max*2");
      applyStimulus(3'b001, 1'b1, 32'hFFFF_FFFD, 32'd5, 0, "mult -3*5");
      applyStimulus(3'b001, 1'b1, 32'hFFFF_FFFD, 32'd5, 1, "mult rd_hilo");
      applyStimulus(3'b010, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div -7/2");
      applyStimulus(3'b010, 1'b0, 32'd100, 32'd7, 2, "divu 100/7 held start");
      applyStimulus(3'b010, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div overflow");
      applyStimulus(3'b010, 1'b1, 32'h0000_1234, 32'd0, 0, "div by zero");
      applyStimulus(3'b001, 1'b1, 32'h8000_0000, 32'h8000_0000, 0, "mult minint^2");
      applyStimulus(3'b011, 1'b0, 32'h0000_CAFE, 32'd0, 0, "mthi");
      applyStimulus(3'b100, 1'b0, 32'h0000_BEEF, 32'd0, 0, "mtlo");
      applyStimulus(3'b000, 1'b0, 32'h1111_1111, 32'd3, 0, "noop func");

      // start together with flush must be dropped entirely
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      func  = 3'b011;
      a     = 32'h0BAD_0BAD;
      @(negedge clk);
      func = 3'b001;
      b    = 32'd9;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      func  = 3'b000;
      #1;
      checkOutput("flush busy", {63'd0, busy}, 64'd0);
      checkOutput("flush hi", {32'd0, hi}, {32'd0, modelHi});
      checkOutput("flush lo", {32'd0, lo}, {32'd0, modelLo});

      for (int i = 0; i < 6; i++) begin
         applyStimulus(3'($urandom_range(1, 2)), 1'($urandom), $urandom, $urandom, 0, "random op");
      end

      // reset in the middle of a DIVU drops the result
      @(negedge clk);
      start   = 1'b1;
      func    = 3'b010;
      is_sign = 1'b0;
      a       = 32'd1000;
      b       = 32'd3;
      @(negedge clk);
      start = 1'b0;
      func  = 3'b000;
      repeat (9) @(negedge clk);
      checkOutput("divu busy before reset", {63'd0, busy}, 64'd1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("mid reset hi", {32'd0, hi}, 64'd0);
      checkOutput("mid reset lo", {32'd0, lo}, 64'd0);
      checkOutput("mid reset busy", {63'd0, busy}, 64'd0);
      modelHi = 32'd0;
      modelLo = 32'd0;
      applyStimulus(3'b100, 1'b0, 32'h0000_0055, 32'd0, 0, "mtlo after reset");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
